// File: rtl/bin2bcd_converter_if.sv
// Request/result bundle between a binary source and the BCD converter.
// The master drives the conversion request; the slave returns status and digits.
interface bin2bcd_converter_if #(
    parameter int WIDTH = 14
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       digit_1;
    logic [3:0]       digit_2;
    logic [3:0]       digit_3;
    logic [3:0]       digit_4;

    modport master (
        output start, bin,
        input  busy, done, ovf, digit_1, digit_2, digit_3, digit_4
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, digit_1, digit_2, digit_3, digit_4
    );
endinterface

// File: rtl/bin2bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Digits are registered only at the end, so the display never sees partial results.
//
//   state  | meaning
//   IDLE   | waiting for start; digits hold the last result
//   SHIFT  | add-3 adjust and shift one bit per cycle, WIDTH cycles
//   FINISH | publish digits and ovf, pulse done
module bin2bcd_converter #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic              clk,
    input  logic              rst_n,
    bin2bcd_converter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [3:0]       LAST_CNT = 4'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   binreg;
    logic [15:0]        scratch;
    logic [3:0]         cnt;
    logic               ovf_lat;
    logic [15:0]        adj;
    logic [WIDTH+15:0]  shifted;

    // Nibbles of 5..9 become 8..12, so the add never carries into the next nibble.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    assign shifted = {adj, binreg} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            binreg      <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_lat     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.ovf     <= 1'b0;
            bus.digit_1 <= '0;
            bus.digit_2 <= '0;
            bus.digit_3 <= '0;
            bus.digit_4 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        binreg   <= (bus.bin > MAX_V) ? MAX_V : bus.bin;
                        ovf_lat  <= (bus.bin > MAX_V);
                        scratch  <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, binreg} <= shifted;
                    cnt               <= cnt + 4'd1;
                    if (cnt == LAST_CNT)
                        state <= FINISH;
                end
                FINISH: begin
                    bus.digit_1 <= scratch[3:0];
                    bus.digit_2 <= scratch[7:4];
                    bus.digit_3 <= scratch[11:8];
                    bus.digit_4 <= scratch[15:12];
                    bus.ovf     <= ovf_lat;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
